// File: rtl/proc_pkg.sv
// Processor-wide definitions shared by the ALU, decoder and PC control stage:
// opcode encodings, the default PC width and the per-cycle classification type.
package proc_pkg;

  localparam int PC_W_DEF = 8;

  localparam logic [4:0] OP_ADD  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b10000;
  localparam logic [4:0] OP_JPC  = 5'b10001;
  localparam logic [4:0] OP_BRFL = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  typedef enum logic [1:0] {
    CYC_IDLE_INC,
    CYC_REDIRECT,
    CYC_ERROR_INC
  } cycle_kind_e;

  function automatic logic is_branch_op(input logic [4:0] op);
    return (op == OP_JR) || (op == OP_JPC) || (op == OP_BRFL);
  endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address LIFO. Push and pop are mutually exclusive and must only be
// requested when not full / not empty respectively; the caller guards this.
module ret_addr_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             full,
  output logic             empty,
  output logic [SW-1:0]    sp
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SW-1:0]    sp_q, sp_d;
  logic [SW-1:0]    sp_m1;

  assign sp_m1    = sp_q - SW'(1);
  assign top_data = mem_q[sp_m1[AW-1:0]];
  assign full     = (sp_q == SW'(DEPTH));
  assign empty    = (sp_q == '0);
  assign sp       = sp_q;

  always_comb begin
    sp_d = sp_q;
    if (push)     sp_d = sp_q + SW'(1);
    else if (pop) sp_d = sp_m1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // NOTE: storage is deliberately not reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[sp_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pc_control_unit.sv
// PC register and control-flow resolution downstream of the ALU: JR/JPC/BRFL/
// CALL/RET redirects, return-address stack, flush pulse and sticky error flag.
module pc_control_unit
  import proc_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         ex_valid,
  input  logic [4:0]                   alu_control,
  input  logic                         zero,
  input  logic [31:0]                  branch_target,
  input  logic [31:0]                  alu_result,
  input  logic                         err_clr,
  output logic [PC_W-1:0]              pc,
  output logic                         flush,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         cf_err
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            cf_err_q, cf_err_d;

  cycle_kind_e     kind;
  logic [PC_W-1:0] target;
  logic            push, pop, full, empty;
  logic [PC_W-1:0] top_data;
  logic            take, range_bad;
  logic            unused_hi;

  assign unused_hi = ^alu_result[31:PC_W];

  ret_addr_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (alu_result[PC_W-1:0]),
    .top_data  (top_data),
    .full      (full),
    .empty     (empty),
    .sp        (sp)
  );

  assign take      = ex_valid && !stall && zero;
  assign range_bad = |branch_target[31:PC_W];

  // Classify the cycle; stall forces IDLE_INC through take, and the PC mux holds.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    kind   = CYC_IDLE_INC;
    target = branch_target[PC_W-1:0];
    push   = 1'b0;
    pop    = 1'b0;
    if (take) begin
      if (is_branch_op(alu_control)) begin
        kind = range_bad ? CYC_ERROR_INC : CYC_REDIRECT;
      end else if (alu_control == OP_CALL) begin
        if (range_bad || full) begin
          kind = CYC_ERROR_INC;
        end else begin
          kind = CYC_REDIRECT;
          push = 1'b1;
        end
      end else if (alu_control == OP_RET) begin
        if (empty) begin
          kind = CYC_ERROR_INC;
        end else begin
          kind   = CYC_REDIRECT;
          pop    = 1'b1;
          target = top_data;
        end
      end
    end
  end

  always_comb begin
    pc_d     = pc_q + PC_W'(1);
    flush_d  = 1'b0;
    cf_err_d = err_clr ? 1'b0 : cf_err_q;
    if (stall) begin
      pc_d = pc_q;
    end else if (kind == CYC_REDIRECT) begin
      pc_d    = target;
      flush_d = 1'b1;
    end
    // Set wins over a same-cycle clear.
    if (kind == CYC_ERROR_INC) cf_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      flush_q  <= 1'b0;
      cf_err_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      flush_q  <= flush_d;
      cf_err_q <= cf_err_d;
    end
  end

  assign pc     = pc_q;
  assign flush  = flush_q;
  assign cf_err = cf_err_q;

endmodule

// File: tb/tb_pc_control_unit.sv
// Directed scoreboard bench for pc_control_unit: each step queues the state
// expected after the next rising edge; a negedge monitor pops and compares.
module tb_pc_control_unit;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic [4:0]  alu_control = OP_ADD;
  logic        zero = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] alu_result = '0;
  logic        err_clr = 1'b0;
  logic [7:0]  pc;
  logic        flush;
  logic [2:0]  sp;
  logic        cf_err;

  typedef struct packed {
    logic [7:0] pc;
    logic       flush;
    logic [2:0] sp;
    logic       cf_err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  pc_control_unit #(.PC_W(8), .STACK_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .ex_valid      (ex_valid),
    .alu_control   (alu_control),
    .zero          (zero),
    .branch_target (branch_target),
    .alu_result    (alu_result),
    .err_clr       (err_clr),
    .pc            (pc),
    .flush         (flush),
    .sp            (sp),
    .cf_err        (cf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the outputs settled after the last rising edge are compared here.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check({n, ".pc"},     {24'h0, pc},     {24'h0, e.pc});
      check({n, ".flush"},  {31'h0, flush},  {31'h0, e.flush});
      check({n, ".sp"},     {29'h0, sp},     {29'h0, e.sp});
      check({n, ".cf_err"}, {31'h0, cf_err}, {31'h0, e.cf_err});
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input string name, input logic rst_v, input logic stall_v,
                      input logic valid_v, input logic [4:0] op, input logic zero_v,
                      input logic [31:0] bt, input logic [31:0] ar, input logic clr_v,
                      input logic [7:0] e_pc, input logic e_flush,
                      input logic [2:0] e_sp, input logic e_err);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n         = rst_v;
    stall         = stall_v;
    ex_valid      = valid_v;
    alu_control   = op;
    zero          = zero_v;
    branch_target = bt;
    alu_result    = ar;
    err_clr       = clr_v;
    e.pc = e_pc; e.flush = e_flush; e.sp = e_sp; e.cf_err = e_err;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic idle(input string name, input logic [7:0] e_pc,
                      input logic [2:0] e_sp, input logic e_err);
    step(name, 1'b1, 1'b0, 1'b0, OP_ADD, 1'b0, 32'h0, 32'h0, 1'b0, e_pc, 1'b0, e_sp, e_err);
  endtask

  task automatic op_do(input string name, input logic [4:0] op, input logic [31:0] bt,
                       input logic [31:0] ar, input logic clr_v, input logic [7:0] e_pc,
                       input logic e_flush, input logic [2:0] e_sp, input logic e_err);
    step(name, 1'b1, 1'b0, 1'b1, op, 1'b1, bt, ar, clr_v, e_pc, e_flush, e_sp, e_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++)
      step("reset_hold", 1'b0, 1'b0, 1'b0, OP_ADD, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    for (int i = 1; i <= 5; i++) idle("inc_after_reset", 8'(i), 3'd0, 1'b0);

    op_do("jpc",         OP_JPC,  32'h20, 32'h0, 1'b0, 8'h20, 1'b1, 3'd0, 1'b0);
    idle ("jpc_next",    8'h21, 3'd0, 1'b0);
    op_do("call",        OP_CALL, 32'h40, 32'h0A, 1'b0, 8'h40, 1'b1, 3'd1, 1'b0);
    idle ("call_next",   8'h41, 3'd1, 1'b0);
    op_do("ret",         OP_RET,  32'h77, 32'h0, 1'b0, 8'h0A, 1'b1, 3'd0, 1'b0);
    idle ("ret_next",    8'h0B, 3'd0, 1'b0);

    op_do("jr_b2b",      OP_JR,   32'h30, 32'h0, 1'b0, 8'h30, 1'b1, 3'd0, 1'b0);
    op_do("brfl_b2b",    OP_BRFL, 32'h31, 32'h0, 1'b0, 8'h31, 1'b1, 3'd0, 1'b0);
    idle ("b2b_next",    8'h32, 3'd0, 1'b0);
    step ("jr_zero0", 1'b1, 1'b0, 1'b1, OP_JR, 1'b0, 32'h90, 32'h0, 1'b0, 8'h33, 1'b0, 3'd0, 1'b0);
    op_do("add_zero1",   OP_ADD,  32'h90, 32'h0, 1'b0, 8'h34, 1'b0, 3'd0, 1'b0);
    step ("jr_novalid", 1'b1, 1'b0, 1'b0, OP_JR, 1'b1, 32'h90, 32'h0, 1'b0, 8'h35, 1'b0, 3'd0, 1'b0);

    op_do("call1",       OP_CALL, 32'h50, 32'h01, 1'b0, 8'h50, 1'b1, 3'd1, 1'b0);
    op_do("call2",       OP_CALL, 32'h60, 32'h02, 1'b0, 8'h60, 1'b1, 3'd2, 1'b0);
    op_do("call3",       OP_CALL, 32'h70, 32'h03, 1'b0, 8'h70, 1'b1, 3'd3, 1'b0);
    op_do("call4",       OP_CALL, 32'h80, 32'h04, 1'b0, 8'h80, 1'b1, 3'd4, 1'b0);
    op_do("call_ovf",    OP_CALL, 32'h90, 32'h05, 1'b0, 8'h81, 1'b0, 3'd4, 1'b1);
    idle ("err_sticky",  8'h82, 3'd4, 1'b1);
    step ("err_clr", 1'b1, 1'b0, 1'b0, OP_ADD, 1'b0, 32'h0, 32'h0, 1'b1, 8'h83, 1'b0, 3'd4, 1'b0);
    op_do("ret4",        OP_RET,  32'h0, 32'h0, 1'b0, 8'h04, 1'b1, 3'd3, 1'b0);
    op_do("ret3",        OP_RET,  32'h0, 32'h0, 1'b0, 8'h03, 1'b1, 3'd2, 1'b0);
    op_do("ret2",        OP_RET,  32'h0, 32'h0, 1'b0, 8'h02, 1'b1, 3'd1, 1'b0);
    op_do("ret1",        OP_RET,  32'h0, 32'h0, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0);
    op_do("ret_udf",     OP_RET,  32'h0, 32'h0, 1'b0, 8'h02, 1'b0, 3'd0, 1'b1);

    op_do("jr_range_clr", OP_JR,  32'h100, 32'h0, 1'b1, 8'h03, 1'b0, 3'd0, 1'b1);
    step ("clr2", 1'b1, 1'b0, 1'b0, OP_ADD, 1'b0, 32'h0, 32'h0, 1'b1, 8'h04, 1'b0, 3'd0, 1'b0);
    op_do("jr_range",    OP_JR,   32'h100, 32'h0, 1'b0, 8'h05, 1'b0, 3'd0, 1'b1);
    step ("clr3", 1'b1, 1'b0, 1'b0, OP_ADD, 1'b0, 32'h0, 32'h0, 1'b1, 8'h06, 1'b0, 3'd0, 1'b0);
    op_do("call_range",  OP_CALL, 32'h8000_0010, 32'h09, 1'b0, 8'h07, 1'b0, 3'd0, 1'b1);
    step ("clr4", 1'b1, 1'b0, 1'b0, OP_ADD, 1'b0, 32'h0, 32'h0, 1'b1, 8'h08, 1'b0, 3'd0, 1'b0);

    op_do("jr_fe",       OP_JR,   32'hFE, 32'h0, 1'b0, 8'hFE, 1'b1, 3'd0, 1'b0);
    idle ("to_ff",       8'hFF, 3'd0, 1'b0);
    op_do("call_at_ff",  OP_CALL, 32'h10, 32'h00, 1'b0, 8'h10, 1'b1, 3'd1, 1'b0);
    op_do("ret_to_0",    OP_RET,  32'h55, 32'h0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
    op_do("jr_ff",       OP_JR,   32'hFF, 32'h0, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b0);
    idle ("wrap",        8'h00, 3'd0, 1'b0);

    op_do("pre_stall_err", OP_JR, 32'h100, 32'h0, 1'b0, 8'h01, 1'b0, 3'd0, 1'b1);
    op_do("pre_stall_jr",  OP_JR, 32'h20, 32'h0, 1'b0, 8'h20, 1'b1, 3'd0, 1'b1);
    step ("stall1", 1'b1, 1'b1, 1'b1, OP_CALL, 1'b1, 32'h40, 32'h21, 1'b1, 8'h20, 1'b0, 3'd0, 1'b0);
    step ("stall2", 1'b1, 1'b1, 1'b1, OP_CALL, 1'b1, 32'h40, 32'h21, 1'b0, 8'h20, 1'b0, 3'd0, 1'b0);
    op_do("call_unstall",  OP_CALL, 32'h40, 32'h21, 1'b0, 8'h40, 1'b1, 3'd1, 1'b0);

    // Mid-cycle asynchronous reset while flush=1 and sp=1.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    ex_valid = 1'b0;
    #1;
    check("async_rst.pc",    {24'h0, pc},    32'h0);
    check("async_rst.sp",    {29'h0, sp},    32'h0);
    check("async_rst.flush", {31'h0, flush}, 32'h0);
    idle ("after_async_rst", 8'h01, 3'd0, 1'b0);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
